// File: rtl/sram_arbiter.sv
// sram_arbiter
// Shares one SRAM controller between three requesters: video fetch (reads),
// pen/draw (writes) and an internal full-memory erase sequencer. Priority is
// fixed video > pen > erase and exactly one SRAM operation is in flight.
// Every output is driven straight from a flop.

module sram_arbiter #(
  parameter int unsigned       ADDR_W     = 18,
  parameter int unsigned       DATA_W     = 16,
  parameter logic [ADDR_W-1:0] ERASE_LAST = 18'h3FFFF,
  parameter logic [DATA_W-1:0] ERASE_DATA = 16'h0000
) (
  input  logic              clk,
  input  logic              reset,
  // video fetch path
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_ack,
  output logic [DATA_W-1:0] vid_data,
  // pen / draw path
  input  logic              pen_req,
  input  logic [ADDR_W-1:0] pen_addr,
  input  logic [DATA_W-1:0] pen_data,
  output logic              pen_ack,
  // erase sequencer control
  input  logic              erase_start,
  output logic              erase_busy,
  output logic              erase_done,
  // sram controller side
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] data_write,
  output logic              read,
  output logic              write,
  input  logic              ready,
  input  logic [DATA_W-1:0] data_read,
  // debug
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_STROBE   = 2'd1,
    ST_ACCEPT   = 2'd2,
    ST_COMPLETE = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_VID   = 2'd1,
    OWN_PEN   = 2'd2,
    OWN_ERASE = 2'd3
  } owner_t;

  // FSM and ownership
  state_t              state_q, state_d;
  owner_t              owner_q, owner_d;
  // Set for the single cycle right after a completion. Requesters only see
  // their ack in that cycle and still hold their request, so arbitration is
  // held off for it; this is the dead cycle between operations.
  logic                gap_q, gap_d;

  // Registered SRAM bus
  logic [ADDR_W-1:0]   address_q, address_d;
  logic [DATA_W-1:0]   data_write_q, data_write_d;
  logic                read_q, read_d;
  logic                write_q, write_d;

  // Registered requester responses
  logic                vid_ack_q, vid_ack_d;
  logic [DATA_W-1:0]   vid_data_q, vid_data_d;
  logic                pen_ack_q, pen_ack_d;

  // Erase sequencer
  logic                erase_busy_q, erase_busy_d;
  logic                erase_done_q, erase_done_d;
  logic [ADDR_W-1:0]   erase_addr_q, erase_addr_d;

  // Arbitration result
  owner_t              win_owner_s;
  logic [ADDR_W-1:0]   win_addr_s;
  logic [DATA_W-1:0]   win_data_s;

  // Fixed-priority pick among the pending requesters (video > pen > erase).
  always_comb begin
    win_owner_s = OWN_NONE;
    win_addr_s  = address_q;
    win_data_s  = data_write_q;
    if (vid_req) begin
      win_owner_s = OWN_VID;
      win_addr_s  = vid_addr;
      win_data_s  = data_write_q;
    end else if (pen_req) begin
      win_owner_s = OWN_PEN;
      win_addr_s  = pen_addr;
      win_data_s  = pen_data;
    end else if (erase_busy_q) begin
      win_owner_s = OWN_ERASE;
      win_addr_s  = erase_addr_q;
      win_data_s  = ERASE_DATA;
    end else begin
      win_owner_s = OWN_NONE;
      win_addr_s  = address_q;
      win_data_s  = data_write_q;
    end
  end

  // Next-state, bus latching, completion handling and erase bookkeeping.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    gap_d        = 1'b0;
    address_d    = address_q;
    data_write_d = data_write_q;
    read_d       = 1'b0;
    write_d      = 1'b0;
    vid_ack_d    = 1'b0;
    vid_data_d   = vid_data_q;
    pen_ack_d    = 1'b0;
    erase_done_d = 1'b0;
    erase_busy_d = erase_busy_q;
    erase_addr_d = erase_addr_q;

    // A start is only honoured while no sweep is running. It cannot collide
    // with an erase completion below, since that needs erase_busy_q set.
    if (erase_start && !erase_busy_q) begin
      erase_busy_d = 1'b1;
      erase_addr_d = {ADDR_W{1'b0}};
    end else begin
      erase_busy_d = erase_busy_q;
      erase_addr_d = erase_addr_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (ready && !gap_q && (win_owner_s != OWN_NONE)) begin
          state_d      = ST_STROBE;
          owner_d      = win_owner_s;
          address_d    = win_addr_s;
          data_write_d = win_data_s;
          // Strobe flop is loaded here so it is high exactly in STROBE.
          read_d       = (win_owner_s == OWN_VID);
          write_d      = (win_owner_s == OWN_PEN) || (win_owner_s == OWN_ERASE);
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_STROBE: begin
        state_d = ST_ACCEPT;
      end

      ST_ACCEPT: begin
        // Controller acknowledges the strobe by dropping ready.
        if (!ready) begin
          state_d = ST_COMPLETE;
        end else begin
          state_d = ST_ACCEPT;
        end
      end

      ST_COMPLETE: begin
        if (ready) begin
          state_d = ST_IDLE;
          owner_d = OWN_NONE;
          gap_d   = 1'b1;
          case (owner_q)
            OWN_VID: begin
              vid_data_d = data_read;
              vid_ack_d  = 1'b1;
            end
            OWN_PEN: begin
              pen_ack_d = 1'b1;
            end
            OWN_ERASE: begin
              erase_addr_d = erase_addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
              if (erase_addr_q == ERASE_LAST) begin
                erase_busy_d = 1'b0;
                erase_done_d = 1'b1;
              end else begin
                erase_busy_d = erase_busy_q;
                erase_done_d = 1'b0;
              end
            end
            default: begin
              owner_d = OWN_NONE;
            end
          endcase
        end else begin
          state_d = ST_COMPLETE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        owner_d = OWN_NONE;
      end
    endcase
  end

  // State and output registers; reset drops any in-flight owner without ack.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      owner_q      <= OWN_NONE;
      gap_q        <= 1'b0;
      address_q    <= {ADDR_W{1'b0}};
      data_write_q <= {DATA_W{1'b0}};
      read_q       <= 1'b0;
      write_q      <= 1'b0;
      vid_ack_q    <= 1'b0;
      vid_data_q   <= {DATA_W{1'b0}};
      pen_ack_q    <= 1'b0;
      erase_busy_q <= 1'b0;
      erase_done_q <= 1'b0;
      erase_addr_q <= {ADDR_W{1'b0}};
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      gap_q        <= gap_d;
      address_q    <= address_d;
      data_write_q <= data_write_d;
      read_q       <= read_d;
      write_q      <= write_d;
      vid_ack_q    <= vid_ack_d;
      vid_data_q   <= vid_data_d;
      pen_ack_q    <= pen_ack_d;
      erase_busy_q <= erase_busy_d;
      erase_done_q <= erase_done_d;
      erase_addr_q <= erase_addr_d;
    end
  end

  assign address    = address_q;
  assign data_write = data_write_q;
  assign read       = read_q;
  assign write      = write_q;
  assign vid_ack    = vid_ack_q;
  assign vid_data   = vid_data_q;
  assign pen_ack    = pen_ack_q;
  assign erase_busy = erase_busy_q;
  assign erase_done = erase_done_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter
// Directed stimulus with a scoreboard: each test pushes the SRAM strobes and
// acks it expects onto a queue, and an independent monitor pops and compares
// whenever the DUT shows a strobe, ack or erase_done.

module tb_sram_arbiter;

  localparam int AW = 18;
  localparam int DW = 16;

  localparam int EV_RD    = 0;
  localparam int EV_WR    = 1;
  localparam int EV_VACK  = 2;
  localparam int EV_PACK  = 3;
  localparam int EV_EDONE = 4;

  // wait_for selectors
  localparam int W_VACK  = 0;
  localparam int W_PACK  = 1;
  localparam int W_EDONE = 2;
  localparam int W_WR    = 3;
  localparam int W_COMPL = 4;
  localparam int W_WR2   = 5;

  typedef struct {
    int            kind;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } ev_t;

  ev_t exp_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;
  int  cyc   = 0;

  logic          clk         = 1'b0;
  logic          reset       = 1'b1;
  logic          vid_req     = 1'b0;
  logic [AW-1:0] vid_addr    = '0;
  logic          vid_ack;
  logic [DW-1:0] vid_data;
  logic          pen_req     = 1'b0;
  logic [AW-1:0] pen_addr    = '0;
  logic [DW-1:0] pen_data    = '0;
  logic          pen_ack;
  logic          erase_start = 1'b0;
  logic          erase_busy;
  logic          erase_done;
  logic [AW-1:0] address;
  logic [DW-1:0] data_write;
  logic          rd_stb;
  logic          wr_stb;
  logic          ready       = 1'b1;
  logic [DW-1:0] data_read   = '0;
  logic [1:0]    state_dbg;

  // SRAM controller model knobs
  int            sram_busy = 1;
  logic [DW-1:0] rd_val    = '0;
  int            busy_cnt  = 0;

  sram_arbiter #(
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .ERASE_LAST(18'd7),
    .ERASE_DATA(16'h0000)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .vid_req    (vid_req),
    .vid_addr   (vid_addr),
    .vid_ack    (vid_ack),
    .vid_data   (vid_data),
    .pen_req    (pen_req),
    .pen_addr   (pen_addr),
    .pen_data   (pen_data),
    .pen_ack    (pen_ack),
    .erase_start(erase_start),
    .erase_busy (erase_busy),
    .erase_done (erase_done),
    .address    (address),
    .data_write (data_write),
    .read       (rd_stb),
    .write      (wr_stb),
    .ready      (ready),
    .data_read  (data_read),
    .state_dbg  (state_dbg)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // SRAM controller model: ready drops the cycle after a strobe and stays low
  // for sram_busy cycles; read data is presented as ready rises.
  always @(posedge clk) begin
    if (busy_cnt != 0) begin
      busy_cnt <= busy_cnt - 1;
      if (busy_cnt == 1) ready <= 1'b1;
    end else if (rd_stb || wr_stb) begin
      ready    <= 1'b0;
      busy_cnt <= sram_busy;
      if (rd_stb) data_read <= rd_val;
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, got, exp);
    end
  endtask

  task automatic push(input int k, input logic [AW-1:0] a, input logic [DW-1:0] d);
    ev_t e;
    e.kind = k;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic observe(input int k, input logic [AW-1:0] a, input logic [DW-1:0] d);
    ev_t e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL unexpected_event @%0d: got kind=%0d addr=%h data=%h, required no event", cyc, k, a, d);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.addr !== a || e.data !== d) begin
        n_bad++;
        $display("FAIL event @%0d: got kind=%0d addr=%h data=%h, required kind=%0d addr=%h data=%h",
                 cyc, k, a, d, e.kind, e.addr, e.data);
      end
    end
  endtask

  function automatic bit sig_val(input int sel);
    case (sel)
      W_VACK:  return vid_ack;
      W_PACK:  return pen_ack;
      W_EDONE: return erase_done;
      W_WR:    return wr_stb;
      W_COMPL: return (state_dbg == 2'd3);
      W_WR2:   return wr_stb && (address == 18'd2);
      default: return 1'b0;
    endcase
  endfunction

  // Returns on the falling edge where the selected DUT condition holds.
  task automatic wait_for(input int sel, input int budget, input string name);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      @(negedge clk);
      hit = sig_val(sel);
    end
    if (!hit) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout_%s: got no event in %0d cycles, required event", name, budget);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: compares every DUT-presented event against the scoreboard and
  // checks the bus stays put while an operation is outstanding.
  initial begin
    logic [AW-1:0] stb_addr;
    logic [DW-1:0] stb_data;
    logic          prev_busy;
    stb_addr  = '0;
    stb_data  = '0;
    prev_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (reset == 1'b0) begin
        if (rd_stb) begin
          observe(EV_RD, address, 16'h0000);
          stb_addr = address;
          stb_data = data_write;
        end
        if (wr_stb) begin
          observe(EV_WR, address, data_write);
          stb_addr = address;
          stb_data = data_write;
        end
        if (vid_ack) observe(EV_VACK, 18'h0, vid_data);
        if (pen_ack) observe(EV_PACK, 18'h0, 16'h0000);
        if (erase_done) begin
          observe(EV_EDONE, 18'h0, 16'h0000);
          check("done_busy_fall", 64'({prev_busy, erase_busy}), 64'(2'b10));
        end
        if (state_dbg == 2'd2 || state_dbg == 2'd3)
          check("bus_stable", 64'({address, data_write}), 64'({stb_addr, stb_data}));
      end
      prev_busy = erase_busy;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, required end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ack_c;
    int wr_c;

    // ---- Reset held 2 cycles with pen_req high
    pen_req  = 1'b1;
    pen_addr = 18'h00042;
    pen_data = 16'hA55A;
    push(EV_WR, 18'h00042, 16'hA55A);
    push(EV_PACK, 18'h0, 16'h0000);
    repeat (2) begin
      @(negedge clk);
      check("rst_ctrl", 64'({rd_stb, wr_stb, vid_ack, pen_ack, erase_busy, erase_done, state_dbg}), 64'd0);
      check("rst_bus", 64'({address, data_write, vid_data}), 64'd0);
    end
    reset = 1'b0;
    // Cycle 1 after the last reset edge is IDLE, cycle 2 carries the strobe.
    @(negedge clk);
    check("rst_first_write", 64'({wr_stb, state_dbg}), 64'({1'b1, 2'd1}));
    wait_for(W_PACK, 20, "rst_pen_ack");
    pen_req = 1'b0;
    idle(3);

    // ---- Single video read, 2 busy cycles
    sram_busy = 2;
    rd_val    = 16'hBEEF;
    vid_addr  = 18'h00123;
    push(EV_RD, 18'h00123, 16'h0000);
    push(EV_VACK, 18'h0, 16'hBEEF);
    vid_req = 1'b1;
    wait_for(W_VACK, 20, "vid_ack");
    vid_req = 1'b0;
    idle(4);
    check("vid_data_hold", 64'(vid_data), 64'(16'hBEEF));

    // ---- Video read at the top address, 1 busy cycle
    sram_busy = 1;
    rd_val    = 16'h0001;
    vid_addr  = 18'h3FFFF;
    push(EV_RD, 18'h3FFFF, 16'h0000);
    push(EV_VACK, 18'h0, 16'h0001);
    vid_req = 1'b1;
    wait_for(W_VACK, 20, "vid_ack_top");
    vid_req = 1'b0;
    idle(3);

    // ---- Priority: video and pen raised together
    rd_val   = 16'h5A5A;
    vid_addr = 18'h00777;
    pen_addr = 18'd5;
    pen_data = 16'h00FF;
    push(EV_RD, 18'h00777, 16'h0000);
    push(EV_VACK, 18'h0, 16'h5A5A);
    push(EV_WR, 18'd5, 16'h00FF);
    push(EV_PACK, 18'h0, 16'h0000);
    vid_req = 1'b1;
    pen_req = 1'b1;
    wait_for(W_VACK, 20, "prio_vid_ack");
    ack_c   = cyc;
    vid_req = 1'b0;
    wait_for(W_WR, 20, "prio_pen_write");
    wr_c = cyc;
    // ack cycle, one IDLE selection cycle, then the write strobe
    check("prio_gap", 64'(wr_c - ack_c), 64'd2);
    wait_for(W_PACK, 20, "prio_pen_ack");
    pen_req = 1'b0;
    idle(3);

    // ---- Erase sweep 0..7, then a restart in the erase_done cycle whose
    //      sweep gets a pen write inserted after address 2
    for (int a = 0; a < 8; a++) push(EV_WR, AW'(a), 16'h0000);
    push(EV_EDONE, 18'h0, 16'h0000);
    for (int a = 0; a < 3; a++) push(EV_WR, AW'(a), 16'h0000);
    push(EV_WR, 18'h2A5A5, 16'h1234);
    push(EV_PACK, 18'h0, 16'h0000);
    for (int a = 3; a < 8; a++) push(EV_WR, AW'(a), 16'h0000);
    push(EV_EDONE, 18'h0, 16'h0000);

    erase_start = 1'b1;
    @(negedge clk);
    erase_start = 1'b0;
    check("erase_busy_set", 64'(erase_busy), 64'd1);
    idle(3);
    erase_start = 1'b1;          // while busy: must add no writes
    @(negedge clk);
    erase_start = 1'b0;
    wait_for(W_EDONE, 200, "erase_done1");
    erase_start = 1'b1;          // same cycle as erase_done: accepted
    @(negedge clk);
    erase_start = 1'b0;
    check("erase_restart_busy", 64'(erase_busy), 64'd1);
    pen_addr = 18'h2A5A5;
    pen_data = 16'h1234;
    wait_for(W_WR2, 100, "erase_addr2");
    pen_req = 1'b1;
    wait_for(W_PACK, 60, "interleave_pen_ack");
    pen_req = 1'b0;
    wait_for(W_EDONE, 200, "erase_done2");
    idle(5);
    check("erase_idle_after", 64'({erase_busy, state_dbg}), 64'd0);

    // ---- Reset in COMPLETE of a pen write while an erase is starting
    sram_busy   = 4;
    pen_addr    = 18'h1F00F;
    pen_data    = 16'hC0DE;
    push(EV_WR, 18'h1F00F, 16'hC0DE);
    erase_start = 1'b1;
    pen_req     = 1'b1;
    @(negedge clk);
    erase_start = 1'b0;
    wait_for(W_COMPL, 20, "midop_complete");
    check("midop_busy_before", 64'(erase_busy), 64'd1);
    reset   = 1'b1;
    pen_req = 1'b0;
    @(negedge clk);
    check("midop_reset", 64'({pen_ack, erase_busy, state_dbg, rd_stb, wr_stb}), 64'd0);
    reset = 1'b0;
    idle(12);
    check("midop_after", 64'({erase_busy, state_dbg}), 64'd0);

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Single-port arbiter that shares the external SRAM controller between three requesters. The requesters are the video fetch path (reads), the pen/draw path (writes driven by camera x/y), and an internal full-memory erase sequencer. It sits between the pixel-buffer logic and the `sram` controller. It owns the controller's `address`/`data_write`/`read`/`write` inputs and watches its `ready`/`data_read` outputs. Fixed priority is video > pen > erase, and exactly one SRAM operation is in flight at a time.

## Interface
- `ADDR_W`, 18, SRAM word-address width
- `DATA_W`, 16, SRAM data width
- `ERASE_LAST`, 18'h3FFFF, last address written by an erase sweep (sweep covers 0..ERASE_LAST inclusive)
- `ERASE_DATA`, 16'h0000, word written at every erased address

- `clk`  in  1  system clock; all logic on rising edge
- `reset`  in  1  synchronous, active-high reset
- `vid_req`  in  1  video read request; held high until `vid_ack`
- `vid_addr`  in  ADDR_W  video read address; stable while `vid_req` is high
- `vid_ack`  out  1  one-cycle pulse: read complete, `vid_data` valid this cycle
- `vid_data`  out  DATA_W  read data; holds its value until the next video completion
- `pen_req`  in  1  pen write request; held high until `pen_ack`
- `pen_addr`  in  ADDR_W  pen write address
- `pen_data`  in  DATA_W  pen write data
- `pen_ack`  out  1  one-cycle pulse: write complete
- `erase_start`  in  1  pulse; starts an erase sweep when `erase_busy` is 0, otherwise ignored
- `erase_busy`  out  1  high from the cycle after an accepted `erase_start` until the sweep finishes
- `erase_done`  out  1  one-cycle pulse at the completion of the ERASE_LAST write
- `address`  out  ADDR_W  to sram controller
- `data_write`  out  DATA_W  to sram controller
- `read`  out  1  one-cycle read strobe to sram controller
- `write`  out  1  one-cycle write strobe to sram controller
- `ready`  in  1  sram controller idle flag; drops the cycle after a strobe, rises at completion
- `data_read`  in  DATA_W  sram read data; valid in the cycle `ready` rises after a read
- `state_dbg`  out  2  current FSM state encoding, for the PMOD debug header

## Operation
- FSM states:
  - IDLE=0
  - STROBE=1
  - ACCEPT=2
  - COMPLETE=3
- IDLE:
  - Transition: if `ready`=1 and any request is pending, select the winner, latch owner, `address`, and `data_write`, then go to STROBE.
  - Pending requests: `vid_req`, `pen_req`, or `erase_busy`.
  - Priority: video > pen > erase.
  - Erase writes use `erase_addr` and `ERASE_DATA`.
- STROBE:
  - Assert `read` (video owner) or `write` (pen/erase owner) for exactly this one cycle.
  - Go to ACCEPT.
- ACCEPT:
  - Wait for `ready`=0, then go to COMPLETE.
  - If `ready` is already 0 in the first ACCEPT cycle, go to COMPLETE next cycle.
- COMPLETE:
  - Wait for `ready`=1.
  - In that same cycle, act by owner:
    - video owner: capture `data_read` into `vid_data` and pulse `vid_ack`.
    - pen owner: pulse `pen_ack`.
    - erase owner: increment `erase_addr`; if the written address was ERASE_LAST, clear `erase_busy` and pulse `erase_done`.
  - Go to IDLE.
- `address` and `data_write` remain stable from STROBE through COMPLETE.
- Erase sequencer:
  - An accepted `erase_start` sets `erase_addr`=0 and `erase_busy`=1.
  - `erase_addr` is ADDR_W wide, so no wrap occurs before ERASE_LAST.
- Simultaneous events:
  - A requester whose ack pulses and which re-raises its request in the next cycle is arbitrated normally.
  - Video may therefore starve pen and erase. This is accepted by design: video fetches occupy less than 50% of slots.
- `erase_start` in the same cycle as `erase_done` is accepted, and a new sweep starts.
- Reset mid-operation:
  - All state clears and any in-flight owner is dropped without ack.
  - The erase sweep is aborted and `erase_busy` goes to 0.

## Timing
- Reset values:
  - `read`, `write`, `vid_ack`, `pen_ack`, `erase_busy`, `erase_done` = 0
  - `address`, `data_write`, `vid_data` = 0
  - state = IDLE
- All outputs are registered.
- Minimum transaction length is 4 cycles (IDLE, STROBE, ACCEPT, COMPLETE) with 1-cycle SRAM latency:
  - Request sampled at edge N.
  - Strobe high in cycle N+1.
  - Ack high at N+3 + (SRAM busy cycles − 1).
- Back-to-back transactions: the next winner is selected in the IDLE cycle following the ack cycle, so there is one dead cycle between ops.
- A request that drops before its ack is protocol misuse: the operation still completes and its ack is still issued.

## Test plan
- Reset:
  - Stimulus: assert `reset` for 2 cycles with `pen_req`=1.
  - Required response: all strobes and acks are 0, `state_dbg`=0, and the first `write` appears exactly 2 cycles after `reset` falls.
- Single video read:
  - Stimulus: `vid_addr`=18'h00123; SRAM model returns 16'hBEEF with 2 busy cycles.
  - Required response: `read` pulses once with `address`=18'h00123, then `vid_ack` pulses once with `vid_data`=16'hBEEF.
- Priority:
  - Stimulus: `vid_req` and `pen_req` rise in the same cycle.
  - Required response: the video read is issued first; the pen write (`pen_addr`=5, `pen_data`=16'h00FF) is issued after `vid_ack` plus one IDLE cycle.
- Erase sweep:
  - Stimulus: ERASE_LAST=7; pulse `erase_start`.
  - Required response: 8 writes at addresses 0..7, each with data 0; `erase_done` pulses once after the address-7 write; `erase_busy` falls in the same cycle. A second `erase_start` issued while busy produces no extra writes.
- Interleave:
  - Stimulus: erase in progress; pen request arrives mid-sweep.
  - Required response: the pen write is inserted at the next IDLE; erase resumes at the next unwritten address, with no address skipped or repeated.
- Reset mid-op:
  - Stimulus: assert `reset` in the COMPLETE state of a pen write.
  - Required response: no `pen_ack`, `erase_busy`=0, FSM in IDLE.
